// File: rtl/nexys_starship_hazard_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nexys_starship_hazard_gen
// Purpose  : Break-event source for the four repair state machines. Paces
//            events on the game tick and picks a free target subsystem and a
//            4-bit repair combo from a 16-bit LFSR. Holds the target's request
//            until that subsystem reports broken, or until a timeout expires.
//            The gap between events shrinks as acknowledged events accumulate.
// Ports    : timer_clk     - game tick clock (rising edge)
//            Reset         - asynchronous, active-high
//            play_flag     - start of game
//            gameover_ctrl - end of game, returns the block to IDLE
//            broken[3:0]   - broken flags {right, left, bottom, top}
//            TR/BR/LR/RR_random - registered break requests
//            random_hex    - registered repair combo
//            difficulty    - saturating difficulty level
//            q_HG_*        - one-hot state outputs
// Revision : 1.0 - initial release
// ============================================================================
module nexys_starship_hazard_gen #(
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          BASE_GAP     = 8,
  parameter int          MIN_GAP      = 2,
  parameter int          RAMP_EVENTS  = 4,
  parameter int          FIRE_TIMEOUT = 6
) (
  input  logic       timer_clk,
  input  logic       Reset,
  input  logic       play_flag,
  input  logic       gameover_ctrl,
  input  logic [3:0] broken,
  output logic       TR_random,
  output logic       BR_random,
  output logic       LR_random,
  output logic       RR_random,
  output logic [3:0] random_hex,
  output logic [1:0] difficulty,
  output logic       q_HG_Idle,
  output logic       q_HG_Wait,
  output logic       q_HG_Fire,
  output logic       q_HG_Hold
);

  localparam logic [7:0] BASE_GAP_C  = 8'(BASE_GAP);
  localparam logic [7:0] MIN_GAP_C   = 8'(MIN_GAP);
  localparam logic [7:0] RAMP_LAST_C = 8'(RAMP_EVENTS - 1);
  localparam logic [7:0] FIRE_LAST_C = 8'(FIRE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FIRE = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [15:0] lfsr, lfsr_nxt;
  logic [7:0] cur_gap, cur_gap_nxt;
  logic [7:0] gap_cnt, gap_cnt_nxt;
  logic [7:0] fire_cnt, fire_cnt_nxt;
  logic [7:0] ramp_cnt, ramp_cnt_nxt;
  logic [1:0] target, target_nxt;
  logic [3:0] hex_nxt;
  logic [1:0] diff_nxt;
  logic [3:0] req, req_nxt;
  logic [7:0] gap_dec;

  // Free-target scan: first index, starting at lfsr[5:4], whose broken bit is clear.
  logic       free_found;
  logic [1:0] free_idx;
  logic [1:0] scan_idx;

  always_comb begin
    free_found = 1'b0;
    free_idx   = lfsr[5:4];
    scan_idx   = lfsr[5:4];
    for (int i = 0; i < 4; i++) begin
      scan_idx = lfsr[5:4] + 2'(i);
      if (!free_found && !broken[scan_idx]) begin
        free_found = 1'b1;
        free_idx   = scan_idx;
      end
    end
  end

  // Fibonacci LFSR, taps 16/14/13/11; an all-zero value reloads the seed.
  always_comb begin
    if (lfsr == 16'd0) begin
      lfsr_nxt = LFSR_SEED;
    end else begin
      lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Gap after a difficulty step, floored at MIN_GAP.
  assign gap_dec = (cur_gap > MIN_GAP_C) ? (cur_gap - 8'd1) : MIN_GAP_C;

  always_comb begin
    state_nxt    = state;
    cur_gap_nxt  = cur_gap;
    gap_cnt_nxt  = gap_cnt;
    fire_cnt_nxt = fire_cnt;
    ramp_cnt_nxt = ramp_cnt;
    target_nxt   = target;
    hex_nxt      = random_hex;
    diff_nxt     = difficulty;

    case (state)
      S_IDLE: begin
        cur_gap_nxt  = BASE_GAP_C;
        ramp_cnt_nxt = 8'd0;
        diff_nxt     = 2'd0;
        // Game over held together with play keeps the block parked.
        if (play_flag && !gameover_ctrl) begin
          state_nxt   = S_WAIT;
          gap_cnt_nxt = BASE_GAP_C;
        end
      end
      S_WAIT: begin
        if (gap_cnt != 8'd0) begin
          gap_cnt_nxt = gap_cnt - 8'd1;
        end else if (free_found) begin
          target_nxt   = free_idx;
          hex_nxt      = lfsr[3:0];
          fire_cnt_nxt = 8'd0;
          state_nxt    = S_FIRE;
        end
      end
      S_FIRE: begin
        // Acknowledge is checked before timeout so a same-tick ack wins.
        if (broken[target]) begin
          state_nxt = S_HOLD;
        end else if (fire_cnt == FIRE_LAST_C) begin
          state_nxt   = S_WAIT;
          gap_cnt_nxt = cur_gap;
        end else begin
          fire_cnt_nxt = fire_cnt + 8'd1;
        end
      end
      S_HOLD: begin
        state_nxt = S_WAIT;
        if (ramp_cnt == RAMP_LAST_C) begin
          ramp_cnt_nxt = 8'd0;
          cur_gap_nxt  = gap_dec;
          gap_cnt_nxt  = gap_dec;
          diff_nxt     = (difficulty == 2'd3) ? 2'd3 : (difficulty + 2'd1);
        end else begin
          ramp_cnt_nxt = ramp_cnt + 8'd1;
          gap_cnt_nxt  = cur_gap;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Game over overrides every in-game transition and restores the
    // difficulty settings at once.
    if (gameover_ctrl && (state != S_IDLE)) begin
      state_nxt    = S_IDLE;
      cur_gap_nxt  = BASE_GAP_C;
      ramp_cnt_nxt = 8'd0;
      diff_nxt     = 2'd0;
    end

    req_nxt = (state_nxt == S_FIRE) ? (4'b0001 << target_nxt) : 4'b0000;
  end

  always_ff @(posedge timer_clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      lfsr       <= LFSR_SEED;
      cur_gap    <= BASE_GAP_C;
      gap_cnt    <= 8'd0;
      fire_cnt   <= 8'd0;
      ramp_cnt   <= 8'd0;
      target     <= 2'd0;
      random_hex <= 4'd0;
      difficulty <= 2'd0;
      req        <= 4'd0;
    end else begin
      state      <= state_nxt;
      lfsr       <= lfsr_nxt;
      cur_gap    <= cur_gap_nxt;
      gap_cnt    <= gap_cnt_nxt;
      fire_cnt   <= fire_cnt_nxt;
      ramp_cnt   <= ramp_cnt_nxt;
      target     <= target_nxt;
      random_hex <= hex_nxt;
      difficulty <= diff_nxt;
      req        <= req_nxt;
    end
  end

  assign TR_random = req[0];
  assign BR_random = req[1];
  assign LR_random = req[2];
  assign RR_random = req[3];

  assign q_HG_Idle = (state == S_IDLE);
  assign q_HG_Wait = (state == S_WAIT);
  assign q_HG_Fire = (state == S_FIRE);
  assign q_HG_Hold = (state == S_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_nexys_starship_hazard_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_nexys_starship_hazard_gen
// Purpose  : Directed self-checking bench for nexys_starship_hazard_gen with
//            default parameters (seed ACE1, gap 8, floor 2, ramp 4, timeout 6).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nexys_starship_hazard_gen;

  logic       timer_clk = 1'b0;
  logic       Reset = 1'b0;
  logic       play_flag = 1'b0;
  logic       gameover_ctrl = 1'b0;
  logic [3:0] broken = 4'd0;
  logic       TR_random, BR_random, LR_random, RR_random;
  logic [3:0] random_hex;
  logic [1:0] difficulty;
  logic       q_HG_Idle, q_HG_Wait, q_HG_Fire, q_HG_Hold;

  nexys_starship_hazard_gen dut (
    .timer_clk     (timer_clk),
    .Reset         (Reset),
    .play_flag     (play_flag),
    .gameover_ctrl (gameover_ctrl),
    .broken        (broken),
    .TR_random     (TR_random),
    .BR_random     (BR_random),
    .LR_random     (LR_random),
    .RR_random     (RR_random),
    .random_hex    (random_hex),
    .difficulty    (difficulty),
    .q_HG_Idle     (q_HG_Idle),
    .q_HG_Wait     (q_HG_Wait),
    .q_HG_Fire     (q_HG_Fire),
    .q_HG_Hold     (q_HG_Hold)
  );

  always #5 timer_clk = ~timer_clk;

  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_WAIT = 4'b0010;
  localparam logic [3:0] ST_FIRE = 4'b0100;
  localparam logic [3:0] ST_HOLD = 4'b1000;

  wire [3:0] req_obs = {RR_random, LR_random, BR_random, TR_random};
  wire [3:0] st_obs  = {q_HG_Hold, q_HG_Fire, q_HG_Wait, q_HG_Idle};

  // Reference LFSR; m_prev is the value the DUT used at the latest edge.
  logic [15:0] m_lfsr, m_prev;
  always @(posedge timer_clk or posedge Reset) begin
    if (Reset) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      if (m_lfsr == 16'd0) m_lfsr <= 16'hACE1;
      else m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  int tests  = 0;
  int failed = 0;
  int n, bad, exp_gap, exp_diff;
  logic [3:0] exp_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge timer_clk);
    #1;
  endtask

  task automatic wait_rise(output int cnt);
    cnt = 0;
    while (cnt < 64) begin
      tick();
      cnt++;
      if (req_obs != 4'd0) break;
    end
  endtask

  task automatic wait_fall(output int cnt, output int unstable);
    logic [3:0] h;
    h = random_hex;
    cnt = 0;
    unstable = 0;
    while (cnt < 64) begin
      tick();
      cnt++;
      if (random_hex !== h) unstable++;
      if (req_obs == 4'd0) break;
    end
  endtask

  initial begin
    // Reset state, checked before any clock edge.
    #1 Reset = 1'b1;
    #2;
    chk("rst_state", st_obs, ST_IDLE);
    chk("rst_req", req_obs, 4'd0);
    chk("rst_hex", random_hex, 4'd0);
    chk("rst_diff", difficulty, 2'd0);
    #9 Reset = 1'b0;
    tick();
    chk("idle_stay", st_obs, ST_IDLE);

    // play and gameover together in IDLE: stay.
    play_flag = 1'b1;
    gameover_ctrl = 1'b1;
    tick();
    chk("play_go_idle", st_obs, ST_IDLE);
    gameover_ctrl = 1'b0;
    tick();
    chk("enter_wait", st_obs, ST_WAIT);
    play_flag = 1'b0;

    // First event, no acknowledge.
    wait_rise(n);
    chk("lat_first", n, 9);
    chk("fire_state", st_obs, ST_FIRE);
    exp_req = 4'b0001 << m_prev[5:4];
    chk("req_target1", req_obs, exp_req);
    chk("hex1", random_hex, m_prev[3:0]);
    wait_fall(n, bad);
    chk("timeout_len", n, 6);
    chk("hex_stable1", bad, 0);
    chk("after_timeout", st_obs, ST_WAIT);
    wait_rise(n);
    chk("lat_second", n, 9);
    exp_req = 4'b0001 << m_prev[5:4];
    chk("req_target2", req_obs, exp_req);
    chk("hex2", random_hex, m_prev[3:0]);

    // Ack on the same tick as the timeout wins (acknowledged event 1).
    for (int i = 0; i < 5; i++) tick();
    chk("still_fire", req_obs, exp_req);
    broken = req_obs;
    tick();
    chk("ack_wins", st_obs, ST_HOLD);
    chk("hold_req", req_obs, 4'd0);
    tick();
    broken = 4'd0;
    chk("diff_e1", difficulty, 2'd0);
    wait_rise(n);
    chk("gap_e1", n, 9);

    // Acknowledged events 2..40: ramp and gap floor.
    for (int e = 2; e <= 40; e++) begin
      exp_req = 4'b0001 << m_prev[5:4];
      chk("loop_req", req_obs, exp_req);
      chk("loop_hex", random_hex, m_prev[3:0]);
      broken = req_obs;
      tick();
      chk("loop_hold", st_obs, ST_HOLD);
      chk("loop_hold_req", req_obs, 4'd0);
      tick();
      broken = 4'd0;
      exp_diff = (e / 4 > 3) ? 3 : e / 4;
      exp_gap  = (8 - e / 4 < 2) ? 2 : 8 - e / 4;
      chk("loop_diff", difficulty, exp_diff);
      wait_rise(n);
      chk("loop_gap", n, exp_gap + 1);
    end

    // Busy skip: only right is free.
    broken = req_obs;
    tick();
    tick();
    broken = 4'b0111;
    wait_rise(n);
    chk("busy_gap", n, 3);
    chk("busy_rr1", req_obs, 4'b1000);
    wait_fall(n, bad);
    chk("busy_timeout", n, 6);
    wait_rise(n);
    chk("busy_rr2", req_obs, 4'b1000);

    // All broken: stays in WAIT, no request.
    broken = 4'b1111;
    tick();
    tick();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req_obs != 4'd0 || st_obs != ST_WAIT) bad++;
    end
    chk("all_broken", bad, 0);

    // Game over mid-FIRE with top requested.
    broken = 4'b1110;
    wait_rise(n);
    chk("top_only_lat", n, 1);
    chk("top_req", TR_random, 1'b1);
    gameover_ctrl = 1'b1;
    tick();
    chk("go_req", req_obs, 4'd0);
    chk("go_idle", st_obs, ST_IDLE);
    gameover_ctrl = 1'b0;
    broken = 4'd0;
    tick();
    play_flag = 1'b1;
    tick();
    play_flag = 1'b0;
    chk("new_game_wait", st_obs, ST_WAIT);
    chk("new_game_diff", difficulty, 2'd0);
    wait_rise(n);
    chk("new_game_gap", n, 9);

    // Asynchronous reset during FIRE.
    #2 Reset = 1'b1;
    #1;
    chk("areset_req", req_obs, 4'd0);
    chk("areset_state", st_obs, ST_IDLE);
    chk("areset_hex", random_hex, 4'd0);
    chk("areset_diff", difficulty, 2'd0);
    #2 Reset = 1'b0;
    tick();
    chk("post_reset_idle", st_obs, ST_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nexys_starship_hazard_gen.md
# nexys_starship_hazard_gen

Hazard generator for Nexys Starship: the source side of the break/repair handshake consumed by the four repair state machines (top, bottom, left, right). It paces break events on the slow game tick, picks a pseudo-random target subsystem and a pseudo-random 4-bit repair combo, and holds the target's `*_random` request until that subsystem reports broken. It also shortens the gap between events as the game progresses. It sits between the game controller (`play_flag`, `gameover_ctrl`) and the repair SMs.

## Interface
- `LFSR_SEED`, 16'hACE1, LFSR reset value; must be nonzero.
- `BASE_GAP`, 8, initial ticks between events; range 1-255.
- `MIN_GAP`, 2, floor for the gap; 1 ≤ `MIN_GAP` ≤ `BASE_GAP`.
- `RAMP_EVENTS`, 4, acknowledged events per difficulty step; ≥ 1.
- `FIRE_TIMEOUT`, 6, max ticks a request is held without acknowledge; ≥ 1.
- `timer_clk` in 1: game tick clock; all state updates on its rising edge.
- `Reset` in 1: asynchronous, active-high.
- `play_flag` in 1: start of game.
- `gameover_ctrl` in 1: end of game; returns the block to IDLE.
- `broken` in 4: subsystem broken flags. Bit 0 = top, 1 = bottom, 2 = left, 3 = right.
- `TR_random`, `BR_random`, `LR_random`, `RR_random` out 1 each: registered break requests.
- `random_hex` out 4: registered repair combo; stable whenever any request is high.
- `difficulty` out 2: saturating difficulty level.
- `q_HG_Idle`, `q_HG_Wait`, `q_HG_Fire`, `q_HG_Hold` out 1 each: one-hot state.

## Operation
- **LFSR**
  - 16-bit Fibonacci LFSR, taps 16, 14, 13, 11.
  - Shifts on every tick in every state, so the sequence depends on when play starts.
  - If the LFSR ever reads 0, it reloads `LFSR_SEED`.
- **Registers**
  - `cur_gap` (8 b): reset value `BASE_GAP`.
  - `gap_cnt` (8 b).
  - `fire_cnt` (8 b).
  - `ramp_cnt` (8 b): counts 0 to `RAMP_EVENTS-1`, then wraps.
  - `target` (2 b).
- **IDLE**
  - All requests 0.
  - `cur_gap` = `BASE_GAP`; `ramp_cnt` = 0; `difficulty` = 0.
  - If `play_flag` = 1: go to WAIT and load `gap_cnt` = `cur_gap`.
- **WAIT**
  - While `gap_cnt` ≠ 0, decrement it.
  - At `gap_cnt` = 0, select a target:
    - Start from the candidate `lfsr[5:4]`.
    - Scan candidate, candidate+1, … (mod 4) and take the first index with `broken` = 0.
    - If all four are broken, remain in WAIT at 0 and retry every tick.
  - When a target is found:
    - Latch `target`.
    - Latch `random_hex` = `lfsr[3:0]`.
    - Clear `fire_cnt`.
    - Go to FIRE.
- **FIRE**
  - The request line selected by `target` is 1; all others are 0.
  - If `broken[target]` = 1 (acknowledge): go to HOLD.
  - Else if `fire_cnt` = `FIRE_TIMEOUT-1`: go to WAIT and reload `gap_cnt` = `cur_gap` (missed event, no ramp).
  - Else increment `fire_cnt`.
- **HOLD** (1 tick)
  - All requests 0.
  - If `ramp_cnt` = `RAMP_EVENTS-1`:
    - `ramp_cnt` ← 0.
    - `cur_gap` ← max(`cur_gap`-1, `MIN_GAP`).
    - `difficulty` ← min(`difficulty`+1, 3).
  - Otherwise `ramp_cnt` ← `ramp_cnt`+1.
  - Go to WAIT and load `gap_cnt` with the post-update `cur_gap`.
- **Game over**
  - `gameover_ctrl` = 1 in WAIT, FIRE or HOLD: go to IDLE next tick and clear requests.
  - Game over takes priority over every other transition.
- `random_hex` holds its value outside FIRE; it changes only on the WAIT→FIRE edge.

## Timing
- **Reset**
  - State = IDLE.
  - All requests 0; `random_hex` = 0; `difficulty` = 0.
  - LFSR = `LFSR_SEED`; `cur_gap` = `BASE_GAP`; all counters 0.
- **Output registration**
  - Requests are registered and decoded from state/target registers.
  - They assert on the edge that enters FIRE and deassert on the edge that leaves FIRE.
- **Event latency**
  - Entering WAIT at edge k with gap G and a free target: FIRE is entered at edge k+G+1.
- **Request duration**
  - The request is held for at least 1 tick and at most `FIRE_TIMEOUT` ticks.
  - `random_hex` is valid throughout.
- **Acknowledge sampling**
  - `broken` is sampled at the `timer_clk` edge.
  - An acknowledge arriving in the same tick as the timeout wins: go to HOLD and ramp.
- **Simultaneous inputs**
  - `play_flag` and `gameover_ctrl` both high in IDLE: stay in IDLE.
- **Asynchronous reset**
  - A mid-FIRE `Reset` drops the request immediately.

## Test plan
- Start, no ack:
  - Stimulus: Reset, `BASE_GAP`=8, pulse `play_flag`, hold `broken`=0.
  - Response: exactly one request rises 9 ticks after WAIT entry, holds 6 ticks, falls; the next event follows after a further 9 ticks.
- Ack path and ramp:
  - Stimulus: tie each request back to its `broken` bit one tick later; run 8 events; clear `broken` after each HOLD.
  - Response: `difficulty` goes 0→1 after event 4 and →2 after event 8; gap shrinks from 8 to 7 to 6.
- Gap floor:
  - Stimulus: run 40 acknowledged events.
  - Response: `cur_gap` stops at 2; `difficulty` saturates at 3.
- Busy skip:
  - Stimulus: force `broken`=4'b0111.
  - Response: every request is `RR_random`; with `broken`=4'b1111, no request asserts and the block stays in WAIT.
- Game over mid-FIRE:
  - Stimulus: assert `gameover_ctrl` while `TR_random`=1.
  - Response: request 0 and `q_HG_Idle`=1 on the next tick; `difficulty`=0 and gap restored to 8 on the next game.
- Reset and combo stability:
  - Stimulus: async `Reset` during FIRE.
  - Response: outputs clear without a clock edge.
  - In normal runs, `random_hex` is constant while any request is high and matches the LFSR `[3:0]` at FIRE entry.
